// File: rtl/mat_result_reader.sv
// mat_result_reader
//   Consumer end of the matcher result interface. When isMatching rises, the
//   packed position vector is snapshotted into per-slot shadow registers. Every
//   occupied slot is then streamed out lowest index first, one beat per
//   valid/ready handshake, as (index, x, y). The stream is followed by a single
//   frameDone pulse.
//
// Ports
//   clock       system clock, rising edge
//   nReset      asynchronous reset, active-high (1 = reset)
//   position    ENTRIES packed slots of ADDR_W bits; slot i at [ADDR_W*i +: ADDR_W]
//   isMatching  match-result level from the matcher
//   outReady    downstream accepts the current beat
//   outValid    beat valid
//   outIndex    slot number of the current beat
//   outX/outY   low X_W / upper ADDR_W-X_W bits of the slot address
//   outLast     current beat is the final one of the frame
//   frameDone   one-cycle pulse after the frame finishes
//   busy        high while a frame is in flight (EMIT or DONE)
//   dropCount   saturating count of match events that arrived while busy

// One position slot: shadow copy plus its pending bit.
module mat_result_slot #(
  parameter int ADDR_W    = 15,
  parameter int SKIP_ZERO = 1
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              capture,
  input  logic              clear,
  input  logic [ADDR_W-1:0] slotIn,
  output logic              occupied,
  output logic [ADDR_W-1:0] shadow,
  output logic              pending
);

  // A zero address marks an empty slot unless every slot is to be emitted.
  assign occupied = (SKIP_ZERO != 0) ? (slotIn != '0) : 1'b1;

  always_ff @(posedge clock or posedge nReset) begin
    if (nReset) begin
      shadow  <= '0;
      pending <= 1'b0;
    end else if (capture) begin
      shadow  <= slotIn;
      pending <= occupied;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

endmodule

module mat_result_reader #(
  parameter int ENTRIES   = 16,
  parameter int ADDR_W    = 15,
  parameter int X_W       = 8,
  parameter int SKIP_ZERO = 1,
  localparam int IDX_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic                    clock,
  input  logic                    nReset,
  input  logic [ENTRIES*ADDR_W-1:0] position,
  input  logic                    isMatching,
  input  logic                    outReady,
  output logic                    outValid,
  output logic [IDX_W-1:0]        outIndex,
  output logic [X_W-1:0]          outX,
  output logic [ADDR_W-X_W-1:0]   outY,
  output logic                    outLast,
  output logic                    frameDone,
  output logic                    busy,
  output logic [7:0]              dropCount
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t state, stateNext;

  logic                            matchPrev;
  logic                            rise;
  logic                            capture;
  logic                            fire;
  logic                            capAny;
  logic                            onlyOne;
  logic [ENTRIES-1:0]              mask;
  logic [ENTRIES-1:0]              capMask;
  logic [ENTRIES-1:0]              selOneHot;
  logic [ENTRIES-1:0][ADDR_W-1:0]  shadow;
  logic [IDX_W-1:0]                selIdx;
  logic [ADDR_W-1:0]               selAddr;

  assign rise    = isMatching & ~matchPrev;
  assign capture = (state == IDLE) & rise;
  assign fire    = outValid & outReady;
  assign capAny  = |capMask;

  // Isolate the lowest pending slot; handshake clears exactly that bit.
  assign selOneHot = mask & (~mask + ENTRIES'(1));
  assign onlyOne   = (mask != '0) && ((mask & (mask - ENTRIES'(1))) == '0);

  for (genvar i = 0; i < ENTRIES; i++) begin : gSlot
    mat_result_slot #(
      .ADDR_W   (ADDR_W),
      .SKIP_ZERO(SKIP_ZERO)
    ) uSlot (
      .clock   (clock),
      .nReset  (nReset),
      .capture (capture),
      .clear   (fire & selOneHot[i]),
      .slotIn  (position[ADDR_W*i +: ADDR_W]),
      .occupied(capMask[i]),
      .shadow  (shadow[i]),
      .pending (mask[i])
    );
  end

  // Priority encoder: scanning downward leaves the lowest set slot selected.
  always_comb begin
    selIdx  = '0;
    selAddr = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        selIdx  = IDX_W'(i);
        selAddr = shadow[i];
      end
    end
  end

  always_ff @(posedge clock or posedge nReset) begin
    if (nReset) begin
      state     <= IDLE;
      matchPrev <= 1'b0;
      dropCount <= '0;
    end else begin
      state     <= stateNext;
      matchPrev <= isMatching;
      // Events that arrive mid-frame are counted, never queued.
      if (rise && (state != IDLE) && (dropCount != 8'hFF))
        dropCount <= dropCount + 8'd1;
    end
  end

  always_comb begin
    stateNext = state;
    outValid  = 1'b0;
    outLast   = 1'b0;
    frameDone = 1'b0;
    outIndex  = '0;
    outX      = '0;
    outY      = '0;
    unique case (state)
      IDLE: begin
        if (rise) stateNext = capAny ? EMIT : DONE;
      end
      EMIT: begin
        outValid = 1'b1;
        outIndex = selIdx;
        outX     = selAddr[X_W-1:0];
        outY     = selAddr[ADDR_W-1:X_W];
        outLast  = onlyOne;
        if (outReady && onlyOne) stateNext = DONE;
      end
      DONE: begin
        frameDone = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mat_result_reader.sv
module tb_mat_result_reader;

  localparam int ENTRIES = 16;
  localparam int ADDR_W  = 15;
  localparam int X_W     = 8;

  typedef struct {
    int idx;
    int addr;
  } beat_t;

  typedef struct {
    int idx;
    int x;
    int y;
    int last;
  } seen_t;

  logic                      clock = 1'b0;
  logic                      nReset;
  logic [ENTRIES*ADDR_W-1:0] position;
  logic                      isMatching;
  logic                      outReady;

  logic       outValid, outLast, frameDone, busy;
  logic [3:0] outIndex;
  logic [7:0] outX;
  logic [6:0] outY;
  logic [7:0] dropCount;

  logic       v0, last0, done0, busy0;
  logic [3:0] idx0;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] drop0;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clock = ~clock;

  mat_result_reader #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .X_W(X_W), .SKIP_ZERO(1)) dut (
    .clock(clock), .nReset(nReset), .position(position), .isMatching(isMatching),
    .outReady(outReady), .outValid(outValid), .outIndex(outIndex), .outX(outX),
    .outY(outY), .outLast(outLast), .frameDone(frameDone), .busy(busy),
    .dropCount(dropCount)
  );

  // Same block with every slot emitted; only used for the all-zero frame.
  mat_result_reader #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .X_W(X_W), .SKIP_ZERO(0)) dut0 (
    .clock(clock), .nReset(nReset), .position(position), .isMatching(isMatching),
    .outReady(outReady), .outValid(v0), .outIndex(idx0), .outX(x0),
    .outY(y0), .outLast(last0), .frameDone(done0), .busy(busy0),
    .dropCount(drop0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is the list of occupied slots; beats leave it from the front.
  beat_t mq[$];
  bit    mDone;
  bit    mPrev;
  int    mDrops;

  always @(posedge clock or posedge nReset) begin
    bit r;
    if (nReset) begin
      mq.delete();
      mDone  = 0;
      mPrev  = 0;
      mDrops = 0;
    end else begin
      r     = isMatching && !mPrev;
      mPrev = isMatching;
      if (mq.size() > 0) begin
        if (r && mDrops < 255) mDrops++;
        if (outReady) begin
          void'(mq.pop_front());
          if (mq.size() == 0) mDone = 1;
        end
      end else if (mDone) begin
        if (r && mDrops < 255) mDrops++;
        mDone = 0;
      end else if (r) begin
        for (int i = 0; i < ENTRIES; i++) begin
          int a;
          a = int'(position[ADDR_W*i +: ADDR_W]);
          if (a != 0) mq.push_back('{idx: i, addr: a});
        end
        if (mq.size() == 0) mDone = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic       pValid = 1'b0, pReady = 1'b0;
  logic [3:0] pIdx;
  logic [7:0] pX;
  logic [6:0] pY;
  logic       pLast;

  always @(negedge clock) begin
    bit ev;
    ev = mq.size() > 0;
    chk("outValid",  outValid,  ev);
    chk("outIndex",  outIndex,  ev ? mq[0].idx : 0);
    chk("outX",      outX,      ev ? (mq[0].addr % 256) : 0);
    chk("outY",      outY,      ev ? (mq[0].addr / 256) : 0);
    chk("outLast",   outLast,   mq.size() == 1);
    chk("frameDone", frameDone, mDone);
    chk("busy",      busy,      ev || mDone);
    chk("dropCount", dropCount, mDrops);
    if (!nReset && pValid && !pReady && outValid) begin
      chk("stallIndex", outIndex, pIdx);
      chk("stallX",     outX,     pX);
      chk("stallY",     outY,     pY);
      chk("stallLast",  outLast,  pLast);
    end
    pValid = outValid; pReady = outReady;
    pIdx = outIndex; pX = outX; pY = outY; pLast = outLast;
  end

  // Accepted-beat loggers for the directed sections.
  seen_t seen[$];
  seen_t seen0[$];

  always @(negedge clock) begin
    if (!nReset && outValid && outReady)
      seen.push_back('{idx: int'(outIndex), x: int'(outX), y: int'(outY), last: int'(outLast)});
    if (!nReset && v0 && outReady)
      seen0.push_back('{idx: int'(idx0), x: int'(x0), y: int'(y0), last: int'(last0)});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setSlot(input int i, input int v);
    position[ADDR_W*i +: ADDR_W] = ADDR_W'(v);
  endtask

  task automatic pulseMatch();
    isMatching = 1'b1;
    tick();
    isMatching = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1,0,0...
  task automatic runFrame(input int mode, input int maxCyc);
    bit done;
    done = 0;
    for (int c = 0; c < maxCyc && !done; c++) begin
      outReady = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      @(negedge clock);
      if (frameDone) done = 1;
      tick();
    end
    chk("frameTimeout", done, 1);
    outReady = 1'b0;
  endtask

  task automatic fullPattern();
    for (int i = 0; i < ENTRIES; i++) setSlot(i, 256 * i + i + 1);
  endtask

  initial begin
    bit found;
    nReset = 1'b1; isMatching = 1'b0; position = '0; outReady = 1'b0;

    // Reset and idle
    repeat (3) tick();
    chk("rstValid", outValid, 0);
    chk("rstBusy",  busy, 0);
    chk("rstDrop",  dropCount, 0);
    nReset = 1'b0;
    repeat (20) tick();
    chk("idleValid", outValid, 0);
    chk("idleBusy",  busy, 0);

    // Empty frame: nothing emitted, frameDone right after capture edge
    seen.delete(); seen0.delete();
    outReady = 1'b1;
    pulseMatch();
    @(negedge clock);
    chk("emptyDone",  frameDone, 1);
    chk("emptyValid", outValid, 0);
    tick();
    repeat (20) tick();
    chk("emptyBeats", seen.size(), 0);
    chk("allBeats",   seen0.size(), 16);
    foreach (seen0[i]) begin
      chk("allIdx", seen0[i].idx, i);
      chk("allXY",  seen0[i].x + seen0[i].y, 0);
    end
    outReady = 1'b0;

    // Full frame, ready high
    seen.delete();
    fullPattern();
    pulseMatch();
    runFrame(0, 40);
    chk("fullBeats", seen.size(), 16);
    foreach (seen[i]) begin
      chk("fullIdx",  seen[i].idx, i);
      chk("fullLast", seen[i].last, i == 15);
    end
    if (seen.size() > 3) begin
      chk("beat3X", seen[3].x, 4);
      chk("beat3Y", seen[3].y, 3);
    end
    chk("fullIdleBusy", busy, 0);

    // Sparse frame with backpressure
    seen.delete();
    position = '0;
    setSlot(2, 'h1234); setSlot(9, 'h7FFF); setSlot(15, 'h0001);
    pulseMatch();
    runFrame(1, 60);
    chk("sparseBeats", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("sp0Idx", seen[0].idx, 2);
      chk("sp0X",   seen[0].x, 'h34);
      chk("sp0Y",   seen[0].y, 'h12);
      chk("sp1Idx", seen[1].idx, 9);
      chk("sp1X",   seen[1].x, 'hFF);
      chk("sp1Y",   seen[1].y, 'h7F);
      chk("sp2Idx", seen[2].idx, 15);
      chk("sp2X",   seen[2].x, 'h01);
      chk("sp2Y",   seen[2].y, 'h00);
      chk("sp2Last", seen[2].last, 1);
      chk("sp0Last", seen[0].last + seen[1].last, 0);
    end

    // Overrun: rises while stalled in EMIT are ignored
    seen.delete();
    fullPattern();
    outReady = 1'b0;
    pulseMatch();
    for (int i = 0; i < ENTRIES; i++) setSlot(i, 1 + $urandom_range(0, 32766));
    tick();
    isMatching = 1'b1;
    tick();
    @(negedge clock);
    chk("drop1", dropCount, 1);
    tick();
    for (int k = 0; k < 299; k++) begin
      isMatching = 1'b0; tick();
      isMatching = 1'b1; tick();
    end
    isMatching = 1'b0;
    @(negedge clock);
    chk("drop255", dropCount, 255);
    tick();
    runFrame(0, 40);
    chk("ovrBeats", seen.size(), 16);
    foreach (seen[i]) chk("ovrX", seen[i].x, i + 1);

    // Reset mid-frame
    seen.delete();
    fullPattern();
    outReady = 1'b1;
    pulseMatch();
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clock);
      if (outValid && outIndex == 4'd5) found = 1;
    end
    chk("beat5Seen", found, 1);
    tick();
    nReset = 1'b1;
    #1;
    chk("abortValid", outValid, 0);
    chk("abortDone",  frameDone, 0);
    chk("abortDrop",  dropCount, 0);
    tick(); tick();
    nReset = 1'b0;
    tick();
    seen.delete();
    setSlot(0, 0); setSlot(1, 0); setSlot(2, 0);
    pulseMatch();
    runFrame(0, 40);
    chk("restartBeats", seen.size(), 13);
    if (seen.size() > 0) chk("restartIdx", seen[0].idx, 3);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      outReady = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) isMatching = ~isMatching;
      for (int i = 0; i < ENTRIES; i++)
        setSlot(i, ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 32767)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mat_result_reader.md
Name: mat_result_reader

Overview:
- Consumer end of the matcher result interface: takes the packed `position` vector and the `isMatching` flag from the matching stage.
- On each new match event it snapshots the vector and streams every occupied entry out, one per transfer, as (index, x, y) over a valid/ready handshake.
- Sits between the matching stage and any downstream logger, host bus or overlay logic, so they never sample the wide vector directly.

Parameters:
- ENTRIES, 16: number of position slots packed in `position`.
- ADDR_W, 15: width of one slot; equal to the pixel address width (`refAddr`).
- X_W, 8: low address bits forming x. y = upper ADDR_W-X_W bits (7 by default).
- SKIP_ZERO, 1: 1 = slots equal to 0 are empty and not emitted; 0 = every slot is emitted.

Ports:
- clock  in  1  system clock, rising edge.
- nReset  in  1  asynchronous reset, active-high (1 = reset). Name kept per codebase, polarity fixed as active-high.
- position  in  ENTRIES*ADDR_W (240)  slot i = position[ADDR_W*i+ADDR_W-1 : ADDR_W*i].
- isMatching  in  1  match-result flag from the matcher, level signal.
- outReady  in  1  downstream accepts the current beat.
- outValid  out  1  beat valid.
- outIndex  out  4  slot number of the current beat.
- outX  out  X_W  slot address [X_W-1:0].
- outY  out  ADDR_W-X_W  slot address [ADDR_W-1:X_W].
- outLast  out  1  current beat is the final beat of this frame.
- frameDone  out  1  one-cycle pulse when a frame has finished.
- busy  out  1  high while not IDLE.
- dropCount  out  8  saturating count of ignored match events.

Behaviour:
- Reset (async, nReset=1):
  - State = IDLE; shadow register, pending mask and the stored previous isMatching (matchPrev) are cleared.
  - Outputs all 0: outValid, outLast, frameDone, busy, outIndex, outX, outY, dropCount.
- Event detect: rise = isMatching & ~matchPrev; matchPrev <= isMatching every cycle.
  - If isMatching is already 1 when reset deasserts, a rise is detected on the first edge.
- State IDLE, on rise:
  - Shadow <= position.
  - mask[i] <= SKIP_ZERO ? (slot i != 0) : 1.
  - Next state is EMIT if the new mask is nonzero, else DONE.
- State EMIT:
  - outValid = 1.
  - Selected slot = lowest set bit of mask (priority encoder); outIndex = that slot, outX/outY from its shadow value.
  - outLast = 1 when exactly one mask bit is set.
  - Outputs stay stable while outValid=1 and outReady=0.
  - Handshake = outValid & outReady. It clears the selected mask bit; if outLast, next state is DONE, else stay in EMIT.
  - Throughput is 1 beat per cycle with outReady held high.
- State DONE: frameDone = 1 for exactly this cycle, outValid = 0, next state is IDLE.
- Latency:
  - Rise sampled at edge k → outValid = 1 in the cycle after edge k.
  - Empty frame: frameDone high in the cycle after edge k, with no beats.
- Busy = (state != IDLE).
- Overrun:
  - A rise detected while state != IDLE (EMIT or DONE) is ignored; shadow and mask are not modified.
  - dropCount increments, saturating at 255.
- The position input may change freely after capture; emitted data always comes from the shadow register.
- A reset asserted mid-frame aborts immediately: no frameDone, pending beats are discarded, all outputs take their reset values.
- Slot decode: x = addr mod 2^X_W, y = addr >> X_W, no arithmetic beyond bit slicing.

Test Plan:
- Reset and idle: nReset high 3 cycles then low, isMatching=0 → all outputs 0, busy=0, no outValid for 20 cycles.
- Full frame:
  - Stimulus: slots 0..15 hold addr = 256*i + i+1, one rise, outReady=1.
  - Required: 16 consecutive beats, outIndex 0..15, beat 3 shows X=4 Y=3, outLast only on index 15, frameDone one cycle later, busy then drops.
- Sparse frame with backpressure:
  - Stimulus: only slots 2 (0x1234), 9 (0x7FFF) and 15 (0x0001) are nonzero; outReady toggles 1,0,0,1,...
  - Required:
    - Beats with outIndex 2, 9, 15 only.
    - Beat 9 shows X=0xFF, Y=0x7F; beat 15 shows X=0x01, Y=0x00.
    - Data held stable during stall cycles; outLast only on index 15.
- Empty frame: all slots 0, SKIP_ZERO=1, one rise → no outValid, frameDone in the cycle after the capture edge; with SKIP_ZERO=0 → 16 beats, all X=0 Y=0.
- Overrun: second rise during EMIT with different position data → emitted data unchanged, dropCount=1; 300 such rises → dropCount=255.
- Reset mid-frame: assert nReset after beat 5 of a 16-beat frame → outValid drops asynchronously, no frameDone; a new rise after release starts again from the lowest nonzero slot.
